spi_tx_scheduler: RTL and testbench
===================================

SPI_TX_SCHEDULER -- requirements
Module: spi_tx_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of byte requesters (2..8).
REQ-002 SHALL have parameter DIV, default 2, sclk half-period in clk cycles (>=1).
REQ-003 SHALL have parameter GAP, default 1, clk cycles ss held high between frames (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester byte-available.
REQ-007 SHALL have port req_data  input  NREQ*8  byte of requester k at bits [8k+7:8k].
REQ-008 SHALL have port req_ready  output  NREQ  one-hot grant; byte taken on edge where valid&ready.
REQ-009 SHALL have port sclk  output  1  SPI clock, idle low (mode 0).
REQ-010 SHALL have port mosi  output  1  serial data, LSB first.
REQ-011 SHALL have port ss  output  1  slave select, active-low.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port grant_id  output  max(1,clog2(NREQ))  index of requester owning current frame.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, GAP.
REQ-015 IDLE: req_ready SHALL be combinational, one-hot on winner, zero when no req_valid; all req_ready SHALL be 0 outside IDLE.
REQ-016 Winner SHALL be first asserted requester at or after round-robin pointer ptr, scanning upward with wrap NREQ-1 -> 0.
REQ-017 On accept edge: byte latched into shift register, grant_id <= winner, ptr <= (winner+1) mod NREQ, half-count hc <= 0, divider <= 0, state -> SHIFT.
REQ-018 ptr SHALL change only on accept; with no valid requests ptr holds.
REQ-019 SHIFT: ss=0; sclk = hc[0]; mosi = byte[hc>>1]; hc advances every DIV clk cycles, 0..15.
REQ-020 SHIFT SHALL last exactly 16*DIV cycles (8 rising sclk edges, mosi stable DIV cycles before each); after hc=15 period state -> GAP.
REQ-021 GAP: ss=1, sclk=0, mosi=0 for exactly GAP cycles, then IDLE.
REQ-022 Accept-to-accept minimum SHALL be 1+16*DIV+GAP cycles; first ss low cycle is cycle after accept.
REQ-023 req_valid/req_data changes while not granted SHALL be ignored; byte latched at accept is immune to later req_data changes.
REQ-024 All outputs except req_ready SHALL be registered.
REQ-025 Divider and hc arithmetic SHALL be unsigned, sized to hold DIV-1 and 15 without overflow.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, ss=1, sclk=0, mosi=0, busy=0, grant_id=0, ptr=0, hc=0, shift register 0.
REQ-027 Reset mid-frame SHALL abort the frame with no completion; first grant after release goes to lowest asserted index >= 0.
REQ-028 Any req_ready assertion SHALL be 0 while rst_n low.

Structure
REQ-029 Package spi_pkg SHALL hold state enum (IDLE, SHIFT, GAP), BYTE_W=8, HALF_CNT=16.
REQ-030 Round-robin pick SHALL be a sub-module spi_rr_arbiter (inputs req, ptr; output one-hot grant, index, any).
REQ-031 Single top-level FSM plus datapath; no FIFOs.

Verification
REQ-032 Single request: NREQ=2, DIV=2, GAP=1, req0 byte 0xA5 -> ss low 32 cycles, mosi on rising sclk = 1,0,1,0,0,1,0,1, grant_id=0.
REQ-033 Contention: req0=0x11, req1=0x22 held valid -> frames alternate 0,1,0,1; accepts spaced exactly 34 cycles.
REQ-034 Skip: NREQ=4, only req2 and req0 valid, ptr=1 -> grant order 2,0,2.
REQ-035 Mid-frame reset: assert rst_n low at hc=7 -> same-cycle ss=1, sclk=0, busy=0; after release with req1 only valid, grant to 1.
REQ-036 Data stability: change req_data0 0x3C -> 0xFF one cycle after accept -> transmitted byte remains 0x3C.
REQ-037 Back-pressure: req_valid held in SHIFT/GAP -> req_ready stays 0; GAP=3 gives exactly 3 ss-high cycles before next accept.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : spi_pkg                                                     |
// | Purpose: Shared types and constants for the SPI TX scheduler.        |
// |          state_t  - frame sequencer states                           |
// |          BYTE_W   - bits per transmitted byte                        |
// |          HALF_CNT - sclk half-periods per byte (two per bit)         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package spi_pkg;

  localparam int BYTE_W   = 8;
  localparam int HALF_CNT = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : spi_rr_arbiter                                              |
// | Purpose: Combinational round-robin pick. Returns the first asserted  |
// |          request at or after ptr, scanning upward with wrap.         |
// | Ports  : req   [NREQ-1:0] request vector                             |
// |          ptr   [IDW-1:0]  highest-priority index this round          |
// |          grant [NREQ-1:0] one-hot winner (zero when no request)      |
// |          idx   [IDW-1:0]  winner index                               |
// |          any              at least one request present               |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module spi_rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int w_k;

  // Offset-based scan: offset 0 is ptr itself, so the first hit in
  // increasing offset order is the round-robin winner.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    w_k   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_k = (int'(ptr) + i) % NREQ;
      if (!any && req[w_k]) begin
        any        = 1'b1;
        grant[w_k] = 1'b1;
        idx        = IDW'(w_k);
      end
    end
  end

endmodule : spi_rr_arbiter
`default_nettype wire

// File: rtl/spi_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : spi_tx_scheduler                                            |
// | Purpose: Round-robin byte scheduler feeding a mode-0 SPI master.     |
// |          One byte per frame, LSB first, ss held high GAP cycles      |
// |          between frames.                                             |
// | Ports  : clk, rst_n (async, active-low)                              |
// |          req_valid/req_data  per-requester byte offer                |
// |          req_ready           one-hot grant, combinational in IDLE    |
// |          sclk, mosi, ss      registered SPI pins                     |
// |          busy, grant_id      registered frame status                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module spi_tx_scheduler
  import spi_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int DIV  = 2,
  parameter  int GAP  = 1,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*BYTE_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   sclk,
  output logic                   mosi,
  output logic                   ss,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id
);

  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int HCW = $clog2(HALF_CNT);

  localparam logic [DW-1:0]  c_DIV_LAST = DW'(DIV - 1);
  localparam logic [GW-1:0]  c_GAP_LAST = GW'(GAP - 1);
  localparam logic [HCW-1:0] c_HC_LAST  = HCW'(HALF_CNT - 1);
  localparam logic [IDW-1:0] c_ID_LAST  = IDW'(NREQ - 1);

  state_t              r_state, w_state_nxt;
  logic [HCW-1:0]      r_hc, w_hc_nxt;
  logic [DW-1:0]       r_div, w_div_nxt;
  logic [GW-1:0]       r_gap, w_gap_nxt;
  logic [BYTE_W-1:0]   r_byte, w_byte_nxt;
  logic [IDW-1:0]      r_ptr, w_ptr_nxt;
  logic [IDW-1:0]      r_grant_id, w_gid_nxt;
  logic                r_ss, r_sclk, r_mosi, r_busy;
  logic                w_ss_nxt, w_sclk_nxt, w_mosi_nxt, w_busy_nxt;

  logic [NREQ-1:0]     w_grant;
  logic [IDW-1:0]      w_win;
  logic                w_any;
  logic                w_accept;

  spi_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_win),
    .any   (w_any)
  );

  assign w_accept = (r_state == S_IDLE) && w_any;

  // Gated by rst_n so no grant is offered while the block is held in reset.
  assign req_ready = (rst_n && r_state == S_IDLE) ? w_grant : '0;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_hc       <= '0;
      r_div      <= '0;
      r_gap      <= '0;
      r_byte     <= '0;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_ss       <= 1'b1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hc       <= w_hc_nxt;
      r_div      <= w_div_nxt;
      r_gap      <= w_gap_nxt;
      r_byte     <= w_byte_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant_id <= w_gid_nxt;
      r_ss       <= w_ss_nxt;
      r_sclk     <= w_sclk_nxt;
      r_mosi     <= w_mosi_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_hc_nxt    = r_hc;
    w_div_nxt   = r_div;
    w_gap_nxt   = r_gap;
    w_byte_nxt  = r_byte;
    w_ptr_nxt   = r_ptr;
    w_gid_nxt   = r_grant_id;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SHIFT;
          w_hc_nxt    = '0;
          w_div_nxt   = '0;
          w_byte_nxt  = req_data[w_win*BYTE_W +: BYTE_W];
          w_gid_nxt   = w_win;
          w_ptr_nxt   = (w_win == c_ID_LAST) ? '0 : w_win + 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_div == c_DIV_LAST) begin
          w_div_nxt = '0;
          if (r_hc == c_HC_LAST) begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = '0;
          end else begin
            w_hc_nxt = r_hc + 1'b1;
          end
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap == c_GAP_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pin values are derived from the upcoming state so the registered
  // outputs line up exactly with the state they describe.
  always_comb begin
    w_ss_nxt   = 1'b1;
    w_sclk_nxt = 1'b0;
    w_mosi_nxt = 1'b0;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    if (w_state_nxt == S_SHIFT) begin
      w_ss_nxt   = 1'b0;
      w_sclk_nxt = w_hc_nxt[0];
      w_mosi_nxt = w_byte_nxt[w_hc_nxt[HCW-1:1]];
    end
  end

  assign ss       = r_ss;
  assign sclk     = r_sclk;
  assign mosi     = r_mosi;
  assign busy     = r_busy;
  assign grant_id = r_grant_id;

endmodule : spi_tx_scheduler
`default_nettype wire

// File: tb/tb_spi_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_spi_tx_scheduler                                         |
// | Purpose: Self-checking bench for spi_tx_scheduler with a cycle       |
// |          timeline reference model (accept -> shift -> gap -> idle).  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_spi_tx_scheduler;

  localparam int NREQ      = 4;
  localparam int DIV       = 2;
  localparam int GAP       = 3;
  localparam int IDW       = 2;
  localparam int SHIFT_CYC = 16 * DIV;
  localparam int FRAME     = 1 + SHIFT_CYC + GAP;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*8-1:0]   req_data = '0;
  logic [NREQ-1:0]     req_ready;
  logic                sclk, mosi, ss, busy;
  logic [IDW-1:0]      grant_id;

  always #5 clk = ~clk;

  spi_tx_scheduler #(.NREQ(NREQ), .DIV(DIV), .GAP(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .sclk      (sclk),
    .mosi      (mosi),
    .ss        (ss),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: time since the last accept drives every expectation.
  int         m_ptr    = 0;
  int         m_gid    = 0;
  int         m_since  = 0;
  bit         m_active = 1'b0;
  logic [7:0] m_byte   = '0;

  int         acc_cyc[$];
  int         acc_id[$];
  logic       prev_sclk = 1'b0;
  logic [7:0] rx = '0;
  int         rx_n = 0;
  int         gap_hi = 0;
  int         ss_lo = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++)
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  // One clock cycle: check registered pins, drive inputs, check ready,
  // advance the model across the coming rising edge.
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*8-1:0] d, input logic r);
    logic [3:0]      e;
    logic [NREQ-1:0] e_rdy;
    int              w;
    bit              idle;
    @(negedge clk);
    cyc++;
    if (m_active && m_since < SHIFT_CYC)
      e = {1'b0, ((m_since / DIV) % 2) == 1, m_byte[m_since / (2 * DIV)], 1'b1};
    else if (m_active && m_since < SHIFT_CYC + GAP)
      e = 4'b1001;
    else
      e = 4'b1000;
    check("pins ss/sclk/mosi/busy", {ss, sclk, mosi, busy}, e);
    check("grant_id", grant_id, m_gid);
    if (sclk && !prev_sclk) begin
      rx = {mosi, rx[7:1]};
      rx_n++;
    end
    prev_sclk = sclk;
    if (busy && ss) gap_hi++;
    if (!ss) ss_lo++;
    if (m_active && m_since == SHIFT_CYC) begin
      check("rx_byte", rx, m_byte);
      check("rx_bits", rx_n, 8);
      rx_n = 0;
    end
    if (m_active && m_since == SHIFT_CYC + GAP) begin
      check("gap_len", gap_hi, GAP);
      gap_hi = 0;
    end

    req_valid = v;
    req_data  = d;
    rst_n     = r;
    #1;
    if (!r) begin
      check("reset pins", {ss, sclk, mosi, busy, grant_id}, 6'b100000);
      m_active = 1'b0; m_ptr = 0; m_gid = 0;
      rx_n = 0; gap_hi = 0; prev_sclk = 1'b0;
    end
    idle  = !m_active || m_since >= SHIFT_CYC + GAP;
    w     = r ? pick(v, m_ptr) : -1;
    e_rdy = (idle && w >= 0) ? NREQ'(1 << w) : '0;
    check("req_ready", req_ready, e_rdy);
    if (|(req_valid & req_ready)) begin
      acc_cyc.push_back(cyc);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) acc_id.push_back(i);
    end
    if (idle && w >= 0) begin
      m_byte   = d[8*w +: 8];
      m_gid    = w;
      m_ptr    = (w + 1) % NREQ;
      m_active = 1'b1;
      m_since  = -1;
    end
    if (m_active) m_since++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b1);
  endtask

  initial begin
    // Held in reset with requests present: no grant may be offered
    for (int i = 0; i < 3; i++) step('1, 32'hDEAD_BEEF, 1'b0);
    idle_cycles(2);

    // Single request, byte 0xA5 from requester 0
    ss_lo = 0;
    step(4'b0001, 32'h0000_00A5, 1'b1);
    idle_cycles(FRAME + 2);
    check("A5 ss low cycles", ss_lo, SHIFT_CYC);
    check("A5 grant", acc_id[acc_id.size()-1], 0);

    // Contention from a fresh pointer: 0,1,0,1 spaced one frame apart
    step('0, '0, 1'b0);
    acc_cyc.delete(); acc_id.delete();
    for (int i = 0; i < 3*FRAME + 1; i++) step(4'b0011, 32'h0000_2211, 1'b1);
    idle_cycles(FRAME);
    check("contention accepts", acc_id.size(), 4);
    for (int i = 0; i < 4 && i < acc_id.size(); i++) check("contention order", acc_id[i], i % 2);
    for (int i = 0; i + 1 < acc_cyc.size(); i++)
      check("contention spacing", acc_cyc[i+1] - acc_cyc[i], FRAME);

    // Move pointer to 1, then only requesters 2 and 0: order 2,0,2
    step(4'b0001, 32'h0000_0077, 1'b1);
    idle_cycles(FRAME);
    acc_id.delete();
    for (int i = 0; i < 2*FRAME + 1; i++) step(4'b0101, 32'h0055_0066, 1'b1);
    idle_cycles(FRAME);
    check("skip accepts", acc_id.size(), 3);
    for (int i = 0; i < 3 && i < acc_id.size(); i++) check("skip order", acc_id[i], (i == 1) ? 0 : 2);

    // Data changes right after accept must not reach the wire
    step(4'b0001, 32'h0000_003C, 1'b1);
    step(4'b0001, 32'h0000_00FF, 1'b1);
    for (int i = 0; i < FRAME; i++) step('0, 32'h0000_00FF, 1'b1);

    // Reset during half-period 7, then requester 1 alone
    step(4'b0001, 32'h0000_0081, 1'b1);
    idle_cycles(7 * DIV);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    step(4'b0010, 32'h0000_4200, 1'b1);
    check("post-reset grant", acc_id[acc_id.size()-1], 1);
    idle_cycles(FRAME);

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++)
      step(NREQ'($urandom), $urandom, $urandom_range(0, 299) != 0);
    idle_cycles(FRAME);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_spi_tx_scheduler
`default_nettype wire
